// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the flash sample sequencer.
// Address arithmetic helper keeps the play position inside the audio image.
package flash_seq_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam int SAMPLE_W     = 16;

  localparam logic [FLASH_ADDR_W-1:0] FLASH_MAX_ADDR   = 23'h7FFFF;
  localparam logic [3:0]              FLASH_BYTEENABLE = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    EMIT_1,
    WAIT_TICK,
    EMIT_2,
    STOPPED
  } seq_state_t;

  // Step one word in the play direction, wrapping at either end of the image.
  function automatic logic [FLASH_ADDR_W-1:0] next_addr(
    input logic [FLASH_ADDR_W-1:0] addr,
    input logic                    dir,
    input logic [FLASH_ADDR_W-1:0] max
  );
    if (dir) return (addr == max) ? '0 : addr + 1'b1;
    else     return (addr == '0)  ? max : addr - 1'b1;
  endfunction

endpackage

// File: rtl/flash_sample_sequencer_if.sv
// Avalon-MM read-only bus between the sequencer (master) and the flash controller (slave).
interface flash_sample_sequencer_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) ();

  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic [3:0]        flash_byteenable;
  logic              flash_waitrequest;
  logic [DATA_W-1:0] flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_read, flash_address, flash_byteenable,
    input  flash_waitrequest, flash_readdata, flash_readdatavalid
  );

  modport slave (
    input  flash_read, flash_address, flash_byteenable,
    output flash_waitrequest, flash_readdata, flash_readdatavalid
  );

endinterface

// File: rtl/flash_word_reader.sv
// Owns a single Avalon-MM word read: holds read/address through waitrequest,
// then waits for readdatavalid and latches the returned word.
module flash_word_reader
  import flash_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FLASH_ADDR_W-1:0] addr,
  output logic                    accepted,
  output logic                    done,
  output logic [FLASH_DATA_W-1:0] data,
  output logic [FLASH_DATA_W-1:0] word,
  flash_sample_sequencer_if.master bus
);

  logic                    read_q;
  logic                    waiting_q;
  logic [FLASH_ADDR_W-1:0] address_q;
  logic [FLASH_DATA_W-1:0] word_q;

  assign bus.flash_read       = read_q;
  assign bus.flash_address    = address_q;
  assign bus.flash_byteenable = FLASH_BYTEENABLE;

  assign accepted = read_q && !bus.flash_waitrequest;
  assign done     = waiting_q && bus.flash_readdatavalid;
  assign data     = bus.flash_readdata;
  assign word     = word_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_q    <= 1'b0;
      waiting_q <= 1'b0;
      address_q <= '0;
    end else begin
      if (start && !read_q && !waiting_q) begin
        read_q    <= 1'b1;
        address_q <= addr;
      end else if (accepted) begin
        read_q    <= 1'b0;
        waiting_q <= 1'b1;
      end
      if (done) waiting_q <= 1'b0;
    end
  end

  // NOTE: word_q is pure datapath, only consumed after done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (done) word_q <= bus.flash_readdata;
  end

endmodule

// File: rtl/flash_sample_sequencer.sv
// Plays 16-bit samples from flash, two per 32-bit word, one per sample_tick, forward or reverse.
// Define FLASH_SEQ_LOOP_EN to wrap at the end of the image instead of stopping.
module flash_sample_sequencer
  import flash_seq_pkg::*;
#(
  parameter int                ADDR_W   = flash_seq_pkg::FLASH_ADDR_W,
  parameter int                DATA_W   = flash_seq_pkg::FLASH_DATA_W,
  parameter int                SAMPLE_W = flash_seq_pkg::SAMPLE_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = flash_seq_pkg::FLASH_MAX_ADDR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                play,
  input  logic                dir,
  input  logic                restart,
  flash_sample_sequencer_if.master flash,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                end_reached
);

  seq_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic              dir_q;
  logic              restart_pending;

  logic              start;
  logic              accepted;
  logic              done;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] restart_addr;
  logic              at_end;
  logic [SAMPLE_W-1:0] first_half;
  logic [SAMPLE_W-1:0] second_half;

  // Launch the read in the same edge the tick is seen so flash_read rises one cycle later.
  assign start        = (state == IDLE) && play && sample_tick && !restart;
  assign restart_addr = dir ? '0 : MAX_ADDR;
  assign at_end       = dir_q ? (addr_q == MAX_ADDR) : (addr_q == '0);

  // Forward play walks low half then high half; reverse mirrors it.
  assign first_half  = dir_q ? data[SAMPLE_W-1:0]      : data[DATA_W-1:SAMPLE_W];
  assign second_half = dir_q ? word[DATA_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];

  flash_word_reader u_reader (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr     (addr_q),
    .accepted (accepted),
    .done     (done),
    .data     (data),
    .word     (word),
    .bus      (flash)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      dir_q           <= 1'b1;
      restart_pending <= 1'b0;
      sample_out      <= '0;
      sample_valid    <= 1'b0;
      end_reached     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      end_reached  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (restart) begin
            addr_q <= restart_addr;
          end else if (play && sample_tick) begin
            dir_q <= dir;
            state <= FETCH;
          end
        end

        // The bus transaction must finish; a restart is remembered and applied afterwards.
        FETCH: begin
          if (restart)  restart_pending <= 1'b1;
          if (accepted) state <= WAIT_DATA;
        end

        WAIT_DATA: begin
          if (done) begin
            if (restart || restart_pending) begin
              restart_pending <= 1'b0;
              addr_q          <= restart_addr;
              state           <= IDLE;
            end else begin
              sample_out   <= first_half;
              sample_valid <= 1'b1;
              state        <= EMIT_1;
            end
          end else if (restart) begin
            restart_pending <= 1'b1;
          end
        end

        EMIT_1: begin
          if (restart) begin
            addr_q <= restart_addr;
            state  <= IDLE;
          end else begin
            state <= WAIT_TICK;
          end
        end

        WAIT_TICK: begin
          if (restart) begin
            addr_q <= restart_addr;
            state  <= IDLE;
          end else if (play && sample_tick) begin
            sample_out   <= second_half;
            sample_valid <= 1'b1;
            state        <= EMIT_2;
          end
        end

        EMIT_2: begin
          if (restart) begin
            addr_q <= restart_addr;
            state  <= IDLE;
          end else if (at_end) begin
            end_reached <= 1'b1;
`ifdef FLASH_SEQ_LOOP_EN
            addr_q <= next_addr(addr_q, dir_q, MAX_ADDR);
            state  <= IDLE;
`else
            state  <= STOPPED;
`endif
          end else begin
            addr_q <= next_addr(addr_q, dir_q, MAX_ADDR);
            state  <= IDLE;
          end
        end

        STOPPED: begin
          if (restart) begin
            addr_q <= restart_addr;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Directed bench for flash_sample_sequencer with a small Avalon flash model.
// Honours FLASH_SEQ_LOOP_EN to match the end-of-image behaviour of the build.
module tb_flash_sample_sequencer;
  import flash_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic play = 1'b0;
  logic dir = 1'b1;
  logic restart = 1'b0;
  logic [SAMPLE_W-1:0] sample_out;
  logic sample_valid;
  logic end_reached;

  flash_sample_sequencer_if #(.ADDR_W(FLASH_ADDR_W), .DATA_W(FLASH_DATA_W)) bus ();

  flash_sample_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .play         (play),
    .dir          (dir),
    .restart      (restart),
    .flash        (bus),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .end_reached  (end_reached)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Flash model controls and statistics.
  int stall_cycles = 0;
  int rsp_lat = 2;
  int wait_cnt = 0;
  int rsp_cnt = 0;
  int reads_total = 0;
  int read_hi_total = 0;
  int wait_hi_total = 0;
  logic addr_moved = 1'b0;
  logic prev_read = 1'b0;
  logic [FLASH_ADDR_W-1:0] prev_addr = '0;
  logic [FLASH_ADDR_W-1:0] last_acc_addr = '0;

  function automatic logic [31:0] mem_word(input logic [FLASH_ADDR_W-1:0] a);
    if (a == 23'h0)       return 32'hBBBB_AAAA;
    if (a == 23'h7FFFF)   return 32'h2222_1111;
    if (a == 23'h7FFFE)   return 32'h4444_3333;
    return {8'hC0, a[7:0], 8'hD0, a[7:0]};
  endfunction

  assign bus.flash_waitrequest = bus.flash_read && (wait_cnt < stall_cycles);

  always @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 0;
      rsp_cnt <= 0;
      prev_read <= 1'b0;
      bus.flash_readdatavalid <= 1'b0;
      bus.flash_readdata <= '0;
    end else begin
      bus.flash_readdatavalid <= 1'b0;
      prev_read <= bus.flash_read;
      prev_addr <= bus.flash_address;
      if (rsp_cnt == 1) begin
        bus.flash_readdatavalid <= 1'b1;
        bus.flash_readdata <= mem_word(last_acc_addr);
      end
      if (rsp_cnt != 0) rsp_cnt <= rsp_cnt - 1;
      if (bus.flash_read) begin
        read_hi_total <= read_hi_total + 1;
        if (prev_read && bus.flash_address != prev_addr) addr_moved <= 1'b1;
        if (bus.flash_waitrequest) begin
          wait_cnt <= wait_cnt + 1;
          wait_hi_total <= wait_hi_total + 1;
        end else begin
          wait_cnt <= 0;
          reads_total <= reads_total + 1;
          last_acc_addr <= bus.flash_address;
          rsp_cnt <= rsp_lat;
        end
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  int cyc = 0;
  int sv_cnt = 0;
  int sv_cyc = 0;
  int rdv_cnt = 0;
  int rdv_cyc = 0;
  int end_cnt = 0;
  logic [SAMPLE_W-1:0] last_sample = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.flash_readdatavalid) begin
      rdv_cnt = rdv_cnt + 1;
      rdv_cyc = cyc;
    end
    if (sample_valid) begin
      sv_cnt = sv_cnt + 1;
      sv_cyc = cyc;
      last_sample = sample_out;
    end
    if (end_reached) end_cnt = end_cnt + 1;
  end

  task automatic tick_once();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sv(input int target);
    int n;
    n = 0;
    while (sv_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sv_cnt < target) begin
      bad++;
      $display("FAIL sample_wait: got %0d samples, need %0d", sv_cnt, target);
    end
  endtask

  task automatic get_sample(output logic [SAMPLE_W-1:0] s);
    int t;
    t = sv_cnt + 1;
    tick_once();
    wait_sv(t);
    s = last_sample;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(3);
    total++;
    if (bus.flash_read !== 1'b0 || bus.flash_address !== 23'h0 || sample_out !== 16'h0 ||
        sample_valid !== 1'b0 || end_reached !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: read=%b addr=%h sample=%h valid=%b end=%b, need all zero",
               bus.flash_read, bus.flash_address, sample_out, sample_valid, end_reached);
    end
    total++;
    if (bus.flash_byteenable !== 4'b1111) begin
      bad++;
      $display("FAIL byteenable: got %b need 1111", bus.flash_byteenable);
    end
    reset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_fwd_play();
    logic [SAMPLE_W-1:0] s;
    play = 1'b1;
    dir = 1'b1;
    tick_once();
    total++;
    if (bus.flash_read !== 1'b1 || bus.flash_address !== 23'h0) begin
      bad++;
      $display("FAIL fwd_read_latency: read=%b addr=%h, need 1 / 0", bus.flash_read, bus.flash_address);
    end
    wait_sv(sv_cnt + 1);
    total++;
    if (last_sample !== 16'hAAAA) begin
      bad++;
      $display("FAIL fwd_first: got %h need AAAA", last_sample);
    end
    get_sample(s);
    total++;
    if (s !== 16'hBBBB) begin
      bad++;
      $display("FAIL fwd_second: got %h need BBBB", s);
    end
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h1 || s !== 16'hD001) begin
      bad++;
      $display("FAIL fwd_next_fetch: addr=%h sample=%h, need 000001 / D001", last_acc_addr, s);
    end
    get_sample(s);
    total++;
    if (s !== 16'hC001) begin
      bad++;
      $display("FAIL fwd_next_second: got %h need C001", s);
    end
  endtask

  task automatic test_rev_play();
    logic [SAMPLE_W-1:0] s;
    int e0;
    e0 = end_cnt;
    dir = 1'b0;
    pulse_restart();
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h7FFFF || s !== 16'h2222) begin
      bad++;
      $display("FAIL rev_first: addr=%h sample=%h, need 7FFFF / 2222", last_acc_addr, s);
    end
    get_sample(s);
    total++;
    if (s !== 16'h1111) begin
      bad++;
      $display("FAIL rev_second: got %h need 1111", s);
    end
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h7FFFE || s !== 16'h4444) begin
      bad++;
      $display("FAIL rev_next_fetch: addr=%h sample=%h, need 7FFFE / 4444", last_acc_addr, s);
    end
    get_sample(s);
    idle_cycles(2);
    total++;
    if (s !== 16'h3333 || end_cnt !== e0) begin
      bad++;
      $display("FAIL rev_next_second: sample=%h end_pulses=%0d, need 3333 / 0", s, end_cnt - e0);
    end
  endtask

  task automatic test_stall();
    logic [SAMPLE_W-1:0] s;
    int r0, h0, w0;
    dir = 1'b1;
    pulse_restart();
    r0 = reads_total; h0 = read_hi_total; w0 = wait_hi_total;
    stall_cycles = 5;
    get_sample(s);
    stall_cycles = 0;
    total++;
    if (reads_total - r0 !== 1 || wait_hi_total - w0 !== 5 || read_hi_total - h0 !== 6) begin
      bad++;
      $display("FAIL stall_hold: reads=%0d stalled=%0d read_high=%0d, need 1 / 5 / 6",
               reads_total - r0, wait_hi_total - w0, read_hi_total - h0);
    end
    total++;
    if (addr_moved !== 1'b0) begin
      bad++;
      $display("FAIL stall_addr_stable: address changed while read held");
    end
    total++;
    if (sv_cyc !== rdv_cyc + 1 || s !== 16'hAAAA) begin
      bad++;
      $display("FAIL stall_valid_latency: valid at %0d rdv at %0d sample=%h, need rdv+1 / AAAA",
               sv_cyc, rdv_cyc, s);
    end
    get_sample(s);
    total++;
    if (s !== 16'hBBBB) begin
      bad++;
      $display("FAIL stall_second: got %h need BBBB", s);
    end
  endtask

  task automatic test_restart_wait_data();
    logic [SAMPLE_W-1:0] s;
    int r0, v0, d0;
    dir = 1'b1;
    pulse_restart();
    for (int i = 0; i < 14; i++) get_sample(s);
    total++;
    if (s !== 16'hC006) begin
      bad++;
      $display("FAIL restart_prefill: got %h need C006", s);
    end
    rsp_lat = 6;
    r0 = reads_total; v0 = sv_cnt; d0 = rdv_cnt;
    tick_once();
    pulse_restart();
    total++;
    if (last_acc_addr !== 23'h7) begin
      bad++;
      $display("FAIL restart_fetch_addr: got %h need 000007", last_acc_addr);
    end
    idle_cycles(15);
    rsp_lat = 2;
    total++;
    if (reads_total - r0 !== 1 || rdv_cnt - d0 !== 1 || sv_cnt !== v0) begin
      bad++;
      $display("FAIL restart_discard: reads=%0d data=%0d samples=%0d, need 1 / 1 / 0",
               reads_total - r0, rdv_cnt - d0, sv_cnt - v0);
    end
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h0 || s !== 16'hAAAA) begin
      bad++;
      $display("FAIL restart_refetch: addr=%h sample=%h, need 000000 / AAAA", last_acc_addr, s);
    end
    get_sample(s);
  endtask

  task automatic test_end_of_image();
    logic [SAMPLE_W-1:0] s;
    int e0;
    dir = 1'b0;
    pulse_restart();
    dir = 1'b1;
    e0 = end_cnt;
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h7FFFF || s !== 16'h1111) begin
      bad++;
      $display("FAIL end_first: addr=%h sample=%h, need 7FFFF / 1111", last_acc_addr, s);
    end
    get_sample(s);
    idle_cycles(2);
    total++;
    if (s !== 16'h2222 || end_cnt - e0 !== 1) begin
      bad++;
      $display("FAIL end_pulse: sample=%h end_pulses=%0d, need 2222 / 1", s, end_cnt - e0);
    end
`ifdef FLASH_SEQ_LOOP_EN
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h0 || s !== 16'hAAAA) begin
      bad++;
      $display("FAIL end_wrap: addr=%h sample=%h, need 000000 / AAAA", last_acc_addr, s);
    end
    get_sample(s);
`else
    begin
      int r0, v0;
      r0 = reads_total; v0 = sv_cnt;
      repeat (3) begin
        tick_once();
        idle_cycles(4);
      end
      total++;
      if (reads_total !== r0 || sv_cnt !== v0) begin
        bad++;
        $display("FAIL end_stopped: reads=%0d samples=%0d, need 0 / 0", reads_total - r0, sv_cnt - v0);
      end
      pulse_restart();
      get_sample(s);
      total++;
      if (last_acc_addr !== 23'h0 || s !== 16'hAAAA) begin
        bad++;
        $display("FAIL end_restart: addr=%h sample=%h, need 000000 / AAAA", last_acc_addr, s);
      end
      get_sample(s);
    end
`endif
  endtask

  task automatic test_pause_dir();
    logic [SAMPLE_W-1:0] s;
    int r0, v0;
    play = 1'b0;
    r0 = reads_total; v0 = sv_cnt;
    repeat (10) begin
      tick_once();
      idle_cycles(2);
    end
    total++;
    if (reads_total !== r0 || sv_cnt !== v0 || sample_out !== 16'hBBBB) begin
      bad++;
      $display("FAIL pause_hold: reads=%0d samples=%0d sample=%h, need 0 / 0 / BBBB",
               reads_total - r0, sv_cnt - v0, sample_out);
    end
    play = 1'b1;
    dir = 1'b1;
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h1 || s !== 16'hD001) begin
      bad++;
      $display("FAIL dir_first: addr=%h sample=%h, need 000001 / D001", last_acc_addr, s);
    end
    dir = 1'b0;
    get_sample(s);
    total++;
    if (s !== 16'hC001) begin
      bad++;
      $display("FAIL dir_keep_order: got %h need C001", s);
    end
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h2 || s !== 16'hC002) begin
      bad++;
      $display("FAIL dir_next_fetch: addr=%h sample=%h, need 000002 / C002", last_acc_addr, s);
    end
    get_sample(s);
    total++;
    if (s !== 16'hD002) begin
      bad++;
      $display("FAIL dir_rev_second: got %h need D002", s);
    end
  endtask

  task automatic test_restart_tick();
    logic [SAMPLE_W-1:0] s;
    int r0;
    dir = 1'b1;
    r0 = reads_total;
    @(negedge clk);
    restart = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    sample_tick = 1'b0;
    idle_cycles(6);
    total++;
    if (reads_total !== r0 || bus.flash_read !== 1'b0) begin
      bad++;
      $display("FAIL restart_beats_tick: reads=%0d read=%b, need 0 / 0", reads_total - r0, bus.flash_read);
    end
    get_sample(s);
    total++;
    if (last_acc_addr !== 23'h0 || s !== 16'hAAAA) begin
      bad++;
      $display("FAIL restart_tick_fetch: addr=%h sample=%h, need 000000 / AAAA", last_acc_addr, s);
    end
    get_sample(s);
  endtask

  initial begin
    test_reset();
    test_fwd_play();
    test_rev_play();
    test_stall();
    test_restart_wait_data();
    test_end_of_image();
    test_pause_dir();
    test_restart_tick();
    idle_cycles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
